// File: rtl/td4_run_ctrl.sv
// td4_run_ctrl: run/step/halt sequencer gating the TD4 core with single-cycle cpu_ce pulses.
// Latency: cpu_ce is registered one clk after a divider tick; RUN with N=1 gives back-to-back pulses.
// Backpressure: none, requests are levels sampled every clk; breakpoints only with TD4_BREAKPOINT_EN.
module td4_run_ctrl #(
   parameter int unsigned DIV_FAST  = 1,
   parameter int unsigned DIV_MED   = 10,
   parameter int unsigned DIV_SLOW  = 100,
   parameter int unsigned DIV_XSLOW = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run_req,
   input  logic       step_req,
   input  logic       halt_req,
   input  logic [1:0] div_sel,
   input  logic [3:0] pc,
   input  logic [3:0] bp_addr,
   input  logic       bp_valid,
   output logic       cpu_ce,
   output logic [1:0] state,
   output logic       halted,
   output logic [7:0] icount
);

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } state_t;

   state_t     st_q, st_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] div_q;
   logic [7:0] lim;
   logic       active, stay_active, tick, ce_d, bp_hit;

   // div_sel is registered so a change lands on the following cycle
   always_comb begin
      case (div_q)
         2'd0:    lim = 8'(DIV_FAST - 1);
         2'd1:    lim = 8'(DIV_MED - 1);
         2'd2:    lim = 8'(DIV_SLOW - 1);
         default: lim = 8'(DIV_XSLOW - 1);
      endcase
   end

   assign active = (st_q == ST_RUN) || (st_q == ST_STEP);
   assign tick   = active && (cnt_q >= lim);

`ifdef TD4_BREAKPOINT_EN
   logic skip_q, skip_d;

   // skip lets the first instruction after leaving BREAK execute at the breakpoint address
   assign bp_hit = bp_valid && (pc == bp_addr) && !skip_q;

   always_comb begin
      skip_d = skip_q;
      if (ce_d)
         skip_d = 1'b0;
      if ((st_q == ST_BREAK) && !halt_req && (run_req || step_req))
         skip_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         skip_q <= 1'b0;
      else
         skip_q <= skip_d;
   end
`else
   logic unused_bp;
   assign unused_bp = ^{pc, bp_addr, bp_valid};
   assign bp_hit    = 1'b0;
`endif

   always_comb begin
      st_d = st_q;
      ce_d = 1'b0;
      case (st_q)
         ST_HALT: begin
            if (halt_req)      st_d = ST_HALT;
            else if (step_req) st_d = ST_STEP;
            else if (run_req)  st_d = ST_RUN;
         end
         ST_RUN: begin
            if (halt_req)
               st_d = ST_HALT;
            else if (tick) begin
               if (bp_hit) st_d = ST_BREAK;
               else        ce_d = 1'b1;
            end
         end
         ST_STEP: begin
            if (halt_req)
               st_d = ST_HALT;
            else if (tick) begin
               ce_d = 1'b1;
               st_d = ST_HALT;
            end
         end
         ST_BREAK: begin
            if (halt_req)      st_d = ST_HALT;
            else if (step_req) st_d = ST_STEP;
            else if (run_req)  st_d = ST_RUN;
         end
         default: st_d = ST_HALT;
      endcase
   end

   // divider restarts from 0 on every tick and whenever RUN/STEP is entered or left
   assign stay_active = active && ((st_d == ST_RUN) || (st_d == ST_STEP));
   assign cnt_d       = (stay_active && !tick) ? cnt_q + 8'd1 : 8'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q   <= ST_HALT;
         cnt_q  <= 8'd0;
         div_q  <= 2'd0;
         cpu_ce <= 1'b0;
         icount <= 8'd0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         div_q  <= div_sel;
         cpu_ce <= ce_d;
         icount <= icount + {7'd0, ce_d};
      end
   end

   assign state  = st_q;
   assign halted = (st_q == ST_HALT) || (st_q == ST_BREAK);

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Scoreboard bench for td4_run_ctrl: stimulus predicts each cpu_ce pulse (cycle, icount), a forked monitor checks them.
module tb_td4_run_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
   logic [1:0] div_sel = 2'd0;
   logic [3:0] pc = 4'd0, bp_addr = 4'd0;
   logic       bp_valid = 1'b0;
   logic       cpu_ce, halted;
   logic [1:0] state;
   logic [7:0] icount;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   bit saw_break = 1'b0;
   logic [7:0] exp_icnt = 8'd0;

   typedef struct {
      int         cyc;
      logic [7:0] icnt;
   } exp_t;
   exp_t exp_q[$];

   localparam int DIVS [4] = '{1, 10, 100, 250};

   td4_run_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .run_req  (run_req),
      .step_req (step_req),
      .halt_req (halt_req),
      .div_sel  (div_sel),
      .pc       (pc),
      .bp_addr  (bp_addr),
      .bp_valid (bp_valid),
      .cpu_ce   (cpu_ce),
      .state    (state),
      .halted   (halted),
      .icount   (icount)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, int act, int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   // pc models the core: it advances once per observed cpu_ce pulse
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (state == 2'd3) saw_break = 1'b1;
         if (cpu_ce) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ce", cyc, -1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("ce_cycle", cyc, e.cyc);
               check("ce_icount", int'(icount), int'(e.icnt));
            end
            pc = pc + 4'd1;
         end
      end
   endtask

   task automatic expect_pulse(int c);
      exp_t e;
      exp_icnt = exp_icnt + 8'd1;
      e.cyc  = c;
      e.icnt = exp_icnt;
      exp_q.push_back(e);
   endtask

   // advance to 1 time unit after the posedge that makes cyc == c
   task automatic go(int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
      #1;
      check("rst_state", int'(state), 0);
      check("rst_cpu_ce", int'(cpu_ce), 0);
      check("rst_icount", int'(icount), 0);
      check("rst_halted", int'(halted), 1);
      go(cyc + 2);
      reset = 1'b1;
      exp_icnt = 8'd0;
      go(cyc + 2);
      check("post_rst_state", int'(state), 0);
   endtask

   // request RUN now (cycle a); halt_req is applied at cycle a+len.
   // A RUN entered at edge a+1 ticks every N cycles, so pulse k appears at a + k*N + 1.
   task automatic run_then_halt(int sel, int len);
      int a, n, h;
      n = DIVS[sel];
      a = cyc;
      h = a + len;
      div_sel = 2'(sel);
      run_req = 1'b1;
      for (int k = 1; a + k * n + 1 <= h; k++) expect_pulse(a + k * n + 1);
      go(a + 1);
      while (cyc < h) begin
         run_req  = 1'($urandom_range(0, 1));
         step_req = 1'($urandom_range(0, 1));
         go(cyc + 1);
      end
      run_req = 1'b0; step_req = 1'b0; halt_req = 1'b1;
      go(h + 1);
      halt_req = 1'b0;
      go(h + 3);
      check("run_end_state", int'(state), 0);
      check("run_end_halted", int'(halted), 1);
      check("run_missing_ce", exp_q.size(), 0);
   endtask

   task automatic step_once(int sel);
      int a, n;
      n = DIVS[sel];
      a = cyc;
      div_sel = 2'(sel);
      step_req = 1'b1;
      expect_pulse(a + n + 1);
      go(a + 1);
      step_req = 1'b0;
      while (cyc < a + n) begin
         run_req = 1'($urandom_range(0, 1));
         go(cyc + 1);
      end
      run_req = 1'b0;
      go(a + n + 3);
      check("step_end_state", int'(state), 0);
      check("step_icount", int'(icount), int'(exp_icnt));
      check("step_missing_ce", exp_q.size(), 0);
   endtask

   task automatic bp_scenario();
      bp_addr  = 4'h5;
      bp_valid = 1'b1;
`ifdef TD4_BREAKPOINT_EN
      begin
         int a, m;
         m = (5 - int'(pc)) & 15;
         a = cyc;
         div_sel = 2'd1;
         run_req = 1'b1;
         for (int k = 1; k <= m; k++) expect_pulse(a + k * 10 + 1);
         go(a + 1);
         run_req = 1'b0;
         go(a + (m + 1) * 10 + 3);
         check("bp_state", int'(state), 3);
         check("bp_halted", int'(halted), 1);
         check("bp_pc", int'(pc), 5);
         check("bp_missing_ce", exp_q.size(), 0);
         a = cyc;
         run_req = 1'b1;
         for (int k = 1; k <= 16; k++) expect_pulse(a + k * 10 + 1);
         go(a + 1);
         run_req = 1'b0;
         go(a + 17 * 10 + 3);
         check("bp2_state", int'(state), 3);
         check("bp2_pc", int'(pc), 5);
         check("bp2_missing_ce", exp_q.size(), 0);
         halt_req = 1'b1;
         go(cyc + 1);
         halt_req = 1'b0;
         go(cyc + 2);
         check("bp_exit_state", int'(state), 0);
      end
`else
      run_then_halt(1, 221);
      check("never_break", int'(saw_break), 0);
`endif
      bp_valid = 1'b0;
   endtask

   initial begin
      #2;
      fork
         monitor();
      join_none

      do_reset();
      bp_scenario();

      // run at N=10 for 30 cycles -> three pulses
      do_reset();
      run_then_halt(1, 31);
      check("icount_after_30", int'(icount), 3);

      step_once(0);

      // halt_req dominates run_req/step_req from HALT
      begin
         int a;
         a = cyc;
         run_req = 1'b1; halt_req = 1'b1;
         while (cyc < a + 4) begin
            step_req = 1'($urandom_range(0, 1));
            go(cyc + 1);
         end
         check("prio_state", int'(state), 0);
         run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
         go(cyc + 3);
         check("prio_after_state", int'(state), 0);
      end

      for (int i = 0; i < 8; i++) begin
         int sel;
         sel = int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) run_then_halt(sel, int'($urandom_range(2, 3 * DIVS[sel] + 2)));
         else step_once(sel);
      end

      // 256 back-to-back pulses wrap icount
      do_reset();
      run_then_halt(0, 257);
      check("icount_wrap", int'(icount), 0);

      // reset mid-run suppresses the pending pulse
      begin
         int a;
         a = cyc;
         div_sel = 2'd0;
         run_req = 1'b1;
         for (int k = 1; k <= 18; k++) expect_pulse(a + k + 1);
         go(a + 1);
         run_req = 1'b0;
         go(a + 20);
         do_reset();
         go(cyc + 5);
         check("rst_hold_halt", int'(state), 0);
         check("rst_missing_ce", exp_q.size(), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/td4_run_ctrl.md
TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_FAST, default 1: tick period in clk cycles for div_sel=0.
REQ-002 The block SHALL have parameter DIV_MED, default 10: tick period for div_sel=1.
REQ-003 The block SHALL have parameter DIV_SLOW, default 100: tick period for div_sel=2.
REQ-004 The block SHALL have parameter DIV_XSLOW, default 250: tick period for div_sel=3. All DIV_* values are in the range 1..256.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port run_req, input, 1 bit: level request to run continuously.
REQ-008 The block SHALL have port step_req, input, 1 bit: level request to execute one instruction.
REQ-009 The block SHALL have port halt_req, input, 1 bit: level request to stop.
REQ-010 The block SHALL have port div_sel, input, 2 bits: tick-period select.
REQ-011 The block SHALL have port pc, input, 4 bits: current CPU program counter.
REQ-012 The block SHALL have port bp_addr, input, 4 bits: breakpoint address.
REQ-013 The block SHALL have port bp_valid, input, 1 bit: breakpoint armed.
REQ-014 The block SHALL have port cpu_ce, output, 1 bit: one-clk clock-enable pulse that advances the CPU core by one instruction.
REQ-015 The block SHALL have port state, output, 2 bits: HALT=0, RUN=1, STEP=2, BREAK=3.
REQ-016 The block SHALL have port halted, output, 1 bit: high when state is HALT or BREAK.
REQ-017 The block SHALL have port icount, output, 8 bits: number of cpu_ce pulses issued.

Function
REQ-018 Request priority SHALL be halt_req > step_req > run_req, with all requests sampled every clk cycle.
REQ-019 Divider behaviour:
- 8-bit counter, running only in RUN or STEP; held at 0 in HALT and BREAK.
- Tick when count >= N-1, where N is the DIV_* value selected by div_sel; count then returns to 0.
- A div_sel change takes effect on the next cycle.
REQ-020 HALT transitions: halt_req keeps HALT; step_req goes to STEP; run_req goes to RUN.
REQ-021 RUN behaviour:
- halt_req goes to HALT with no cpu_ce in that cycle.
- On a tick, cpu_ce=1 for exactly one cycle.
- step_req is ignored.
REQ-022 STEP behaviour:
- halt_req goes to HALT with no pulse.
- The first tick produces cpu_ce=1 and a transition to HALT in the same edge.
- run_req and step_req are ignored.
REQ-023 Latency: with N=1, cpu_ce SHALL assert on the first cycle after entering RUN or STEP.
REQ-024 icount SHALL increment by 1 on every cpu_ce pulse and wrap 255->0.
REQ-025 cpu_ce SHALL be registered and never high for two consecutive cycles when N>1; with N=1 in RUN it is continuously high.
REQ-026 Breakpoint rule: in RUN, on a tick where bp_valid=1 and pc==bp_addr, the block SHALL go to BREAK without issuing cpu_ce, unless the skip flag is set.
REQ-027 Skip flag behaviour:
- Set on leaving BREAK by run_req or step_req.
- Cleared after the next cpu_ce.
- Guarantees progress past the breakpoint address.
REQ-028 BREAK transitions: halt_req goes to HALT; step_req goes to STEP; run_req goes to RUN.
REQ-029 STEP SHALL NOT break on a breakpoint.

Reset
REQ-030 On reset=0, and asynchronously, the block SHALL set state=HALT, cpu_ce=0, icount=0, divider=0 and skip=0, so halted=1.
REQ-031 Reset asserted mid-RUN or mid-STEP SHALL suppress any pending cpu_ce; after release the block waits in HALT for a request.

Configuration
REQ-032 With macro TD4_BREAKPOINT_EN defined, REQ-026 to REQ-029 SHALL be implemented.
REQ-033 With TD4_BREAKPOINT_EN undefined:
- bp_addr and bp_valid are present but ignored.
- BREAK is unreachable; state never equals 3.
- No skip flag is built.

Verification
REQ-034 Reset, then run_req=1 for 1 cycle with div_sel=1 (N=10) -> state=1; cpu_ce pulses every 10 cycles; icount=3 after 30 cycles.
REQ-035 From HALT, step_req=1 for 1 cycle with div_sel=0 -> exactly one cpu_ce pulse; state returns to 0; icount +1.
REQ-036 run_req and halt_req asserted together from HALT -> state stays 0; no cpu_ce.
REQ-037 TD4_BREAKPOINT_EN, bp_valid=1, bp_addr=4'h5, pc advanced by the bench on each cpu_ce from 0, run -> BREAK with pc=5 after 5 pulses. Then run_req -> next pulse issued at pc=5; running continues until pc wraps back to 5, where BREAK recurs.
REQ-038 256 pulses in RUN with N=1 -> icount wraps to 0; assert reset mid-run -> cpu_ce=0 and state=0 immediately.
REQ-039 Without TD4_BREAKPOINT_EN, repeat REQ-037 -> no BREAK; state never 3.
